// File: rtl/restoring_divider_if.sv
// Handshake and data bundle between the arithmetic-unit controller and the
// restoring divider.
//   master : controller side, drives Div_En / Dividend / Divisor
//   slave  : divider side, returns Div_Busy / Div_Finsh / Quotient /
//            Remainder / Div_By_Zero / Div_Overflow
interface restoring_divider_if #(
  parameter int Data_Width = 8
);
  logic                         Div_En;
  logic signed [Data_Width-1:0] Dividend;
  logic signed [Data_Width-1:0] Divisor;
  logic                         Div_Busy;
  logic                         Div_Finsh;
  logic signed [Data_Width-1:0] Quotient;
  logic signed [Data_Width-1:0] Remainder;
  logic                         Div_By_Zero;
  logic                         Div_Overflow;

  modport master (
    output Div_En, Dividend, Divisor,
    input  Div_Busy, Div_Finsh, Quotient, Remainder, Div_By_Zero, Div_Overflow
  );

  modport slave (
    input  Div_En, Dividend, Divisor,
    output Div_Busy, Div_Finsh, Quotient, Remainder, Div_By_Zero, Div_Overflow
  );
endinterface

// File: rtl/restoring_divider.sv
// Sequential signed divider using a restoring shift-subtract loop on operand
// magnitudes. A start on Div_En (sampled in IDLE) runs Data_Width iterations,
// then one sign-fixup cycle registers Quotient/Remainder and pulses Div_Finsh.
// Latency is fixed at Data_Width+1 edges from the start edge to Div_Finsh.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset (aborts any operation)
//   div_if : slave side of restoring_divider_if (start, operands, results,
//            busy/finish status, divide-by-zero and overflow flags)
module restoring_divider #(
  parameter int Data_Width    = 8,
  parameter int Counter_Width = $clog2(Data_Width) + 1
) (
  input logic                clk,
  input logic                rst,
  restoring_divider_if.slave div_if
);

  typedef enum logic [1:0] {IDLE, ITER, SIGN, DONE} state_t;

  state_t state, state_nxt;

  logic [Data_Width-1:0]    a_r;
  logic [Data_Width-1:0]    q_r;
  logic [Data_Width-1:0]    dvs_mag;
  logic [Counter_Width-1:0] cnt;
  logic                     dd_neg;
  logic                     dvs_neg;
  logic                     dvs_zero;
  logic                     ovf_case;

  logic [Data_Width:0]      a_shift;
  logic [Data_Width:0]      a_trial;

  function automatic logic [Data_Width-1:0] magnitude(
    input logic signed [Data_Width-1:0] v
  );
    logic [Data_Width-1:0] u;
    u = v;
    // The most-negative value negates to itself, which read unsigned is
    // exactly 2^(Data_Width-1).
    return v[Data_Width-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic [Data_Width-1:0] cond_negate(
    input logic [Data_Width-1:0] v,
    input logic                  neg
  );
    return neg ? (~v + 1'b1) : v;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (div_if.Div_En) state_nxt = ITER;
      ITER:    if (cnt == Counter_Width'(1)) state_nxt = SIGN;
      SIGN:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    div_if.Div_Busy  = (state != IDLE);
    div_if.Div_Finsh = (state == DONE);
  end

  // The working accumulator is Data_Width+1 bits only after the shift. The
  // stored remainder is always below |Divisor| <= 2^(Data_Width-1), so its
  // top bit would always be zero and is not kept.
  always_comb begin
    a_shift = {a_r, q_r[Data_Width-1]};
    a_trial = a_shift - {1'b0, dvs_mag};
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r                 <= '0;
      q_r                 <= '0;
      dvs_mag             <= '0;
      cnt                 <= '0;
      dd_neg              <= 1'b0;
      dvs_neg             <= 1'b0;
      dvs_zero            <= 1'b0;
      ovf_case            <= 1'b0;
      div_if.Quotient     <= '0;
      div_if.Remainder    <= '0;
      div_if.Div_By_Zero  <= 1'b0;
      div_if.Div_Overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (div_if.Div_En) begin
            a_r      <= '0;
            q_r      <= magnitude(div_if.Dividend);
            dvs_mag  <= magnitude(div_if.Divisor);
            cnt      <= Counter_Width'(Data_Width);
            dd_neg   <= div_if.Dividend[Data_Width-1];
            dvs_neg  <= div_if.Divisor[Data_Width-1];
            dvs_zero <= (div_if.Divisor == '0);
            ovf_case <= ($unsigned(div_if.Dividend) == {1'b1, {(Data_Width-1){1'b0}}})
                        && (div_if.Divisor == '1);
          end
        end
        ITER: begin
          // Negative trial (MSB set) means the subtract did not fit: restore.
          a_r <= a_trial[Data_Width] ? a_shift[Data_Width-1:0] : a_trial[Data_Width-1:0];
          q_r <= {q_r[Data_Width-2:0], ~a_trial[Data_Width]};
          cnt <= cnt - 1'b1;
        end
        SIGN: begin
          // With a zero divisor every trial succeeds, so the accumulator ends
          // holding |Dividend|; the normal sign fixup then returns the
          // original dividend as the remainder.
          div_if.Quotient     <= dvs_zero ? '1 : cond_negate(q_r, dd_neg ^ dvs_neg);
          div_if.Remainder    <= cond_negate(a_r, dd_neg);
          div_if.Div_By_Zero  <= dvs_zero;
          div_if.Div_Overflow <= ovf_case;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  restoring_divider_if #(.Data_Width(DW)) dif ();

  restoring_divider #(.Data_Width(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic (truncating division) with the two
  // special cases handled explicitly.
  task automatic model(input int dd, input int dvs,
                       output logic [DW-1:0] q, output logic [DW-1:0] r,
                       output logic dz, output logic ov);
    int qi, ri;
    int mn;
    mn = -(1 <<< (DW - 1));
    dz = 1'b0;
    ov = 1'b0;
    if (dvs == 0) begin
      qi = -1; ri = dd; dz = 1'b1;
    end else if (dd == mn && dvs == -1) begin
      qi = mn; ri = 0; ov = 1'b1;
    end else begin
      qi = dd / dvs; ri = dd % dvs;
    end
    q = qi[DW-1:0];
    r = ri[DW-1:0];
  endtask

  task automatic check_result(input int dd, input int dvs);
    logic [DW-1:0] q, r;
    logic dz, ov;
    model(dd, dvs, q, r, dz, ov);
    check($sformatf("quot %0d/%0d", dd, dvs), $unsigned(dif.Quotient), q);
    check($sformatf("rem %0d/%0d", dd, dvs), $unsigned(dif.Remainder), r);
    check($sformatf("dz %0d/%0d", dd, dvs), dif.Div_By_Zero, dz);
    check($sformatf("ovf %0d/%0d", dd, dvs), dif.Div_Overflow, ov);
  endtask

  // Drives a one-cycle start; returns #1 after the start edge with the
  // operands scrambled so the running operation must not depend on them.
  task automatic start(input int dd, input int dvs);
    @(negedge clk);
    dif.Dividend = dd[DW-1:0];
    dif.Divisor  = dvs[DW-1:0];
    dif.Div_En   = 1'b1;
    @(posedge clk);
    #1;
    dif.Div_En   = 1'b0;
    dif.Dividend = DW'($urandom);
    dif.Divisor  = DW'($urandom);
  endtask

  task automatic wait_finish(output int lat);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      lat++;
      #1;
      if (dif.Div_Finsh === 1'b1) return;
      check("busy_running", dif.Div_Busy, 1);
    end
    check("finish_timeout", dif.Div_Finsh, 1);
  endtask

  task automatic op(input int dd, input int dvs);
    int lat;
    start(dd, dvs);
    wait_finish(lat);
    check("latency", lat, DW + 1);
    check_result(dd, dvs);
    @(posedge clk);
    #1;
    check("finish_single_pulse", dif.Div_Finsh, 0);
    check("busy_drop", dif.Div_Busy, 0);
  endtask

  initial begin
    int lat;
    bit saw;
    int dd, dvs;
    dif.Div_En   = 1'b0;
    dif.Dividend = '0;
    dif.Divisor  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", dif.Div_Busy, 0);
    check("rst_finsh", dif.Div_Finsh, 0);
    check("rst_quot", $unsigned(dif.Quotient), 0);
    check("rst_rem", $unsigned(dif.Remainder), 0);
    check("rst_dz", dif.Div_By_Zero, 0);
    check("rst_ovf", dif.Div_Overflow, 0);
    rst = 1'b0;

    // Directed operands
    op(100, 7);
    check("lit_q_100_7", $unsigned(dif.Quotient), 14);
    check("lit_r_100_7", $unsigned(dif.Remainder), 2);
    op(-100, 7);
    check("lit_q_m100_7", $unsigned(dif.Quotient), 8'hF2);
    check("lit_r_m100_7", $unsigned(dif.Remainder), 8'hFE);
    op(100, -7);
    op(-100, -7);
    op(-128, -1);
    check("lit_ovf", dif.Div_Overflow, 1);
    op(-128, 1);
    op(127, 127);
    op(5, 0);
    check("lit_q_div0", $unsigned(dif.Quotient), 8'hFF);
    op(9, 3);
    op(-7, 0);
    op(-128, 0);
    op(3, 100);

    // Randomized operands
    for (int i = 0; i < 40; i++) begin
      dd  = int'($urandom_range(0, 255)) - 128;
      dvs = (i % 10 == 3) ? 0 : int'($urandom_range(0, 255)) - 128;
      op(dd, dvs);
    end

    // Start request during iteration 3 must be ignored
    start(20, 3);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("busy_before_ignored_req", dif.Div_Busy, 1);
    end
    @(negedge clk);
    dif.Dividend = 8'd50;
    dif.Divisor  = 8'd5;
    dif.Div_En   = 1'b1;
    @(posedge clk);
    #1;
    dif.Div_En = 1'b0;
    check("busy_at_ignored_req", dif.Div_Busy, 1);
    wait_finish(lat);
    check("latency_ignored_req", lat, DW + 1 - 3);
    check_result(20, 3);
    @(posedge clk);
    #1;
    check("busy_drop_ignored", dif.Div_Busy, 0);
    @(posedge clk);
    #1;
    check("no_queued_start", dif.Div_Busy, 0);

    // Back-to-back with Div_En held high: next start on edge DW+3
    @(negedge clk);
    dif.Dividend = 8'd17;
    dif.Divisor  = 8'd4;
    dif.Div_En   = 1'b1;
    @(posedge clk);
    #1;
    dif.Dividend = 8'd33;
    dif.Divisor  = 8'd5;
    wait_finish(lat);
    check("latency_b2b_first", lat, DW + 1);
    check_result(17, 4);
    @(posedge clk);
    #1;
    check("b2b_idle_gap", dif.Div_Busy, 0);
    @(posedge clk);
    #1;
    check("b2b_restart", dif.Div_Busy, 1);
    dif.Div_En = 1'b0;
    wait_finish(lat);
    check("latency_b2b_second", lat, DW + 1);
    check_result(33, 5);
    @(posedge clk);
    #1;

    // Reset during iteration 4 aborts the operation
    op(100, 7);
    start(77, 5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", dif.Div_Busy, 0);
    check("abort_finsh", dif.Div_Finsh, 0);
    check("abort_quot", $unsigned(dif.Quotient), 0);
    check("abort_rem", $unsigned(dif.Remainder), 0);
    check("abort_dz", dif.Div_By_Zero, 0);
    check("abort_ovf", dif.Div_Overflow, 0);
    saw = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (dif.Div_Finsh === 1'b1 || dif.Div_Busy === 1'b1) saw = 1'b1;
    end
    check("no_activity_after_abort", saw, 0);
    op(45, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
